sram_port_arbiter: RTL and testbench

- Two-master arbiter sharing the single SRAM_Controller port between instruction fetch (master 0) and the MEM-stage cache controller (master 1).
- Latches the winning request, drives the controller until it finishes, then returns read data and a one-cycle ready to the winner only.
- Sits between the IF/MEM requesters and SRAM_Controller. Lets instruction memory move to off-chip SRAM without a second controller.

---
 rtl/sram_port_arbiter_if.sv | 59 +++++
 rtl/sram_port_arbiter.sv | 112 +++++++++++
 tb/tb_sram_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
// Bundles the two requester ports, the shared SRAM_Controller port and the
// grant indicator of sram_port_arbiter.
//   m0_* / m1_* : requester read/write enables, address, write data (in),
//                 read data and completion pulse (out)
//   s_*         : request toward SRAM_Controller (out), read data and
//                 ready pulse from it (in)
//   grant       : one-hot current owner, 00 when idle
// Modports:
//   master : the environment side (requesters plus SRAM_Controller)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              m0_rd_en;
  logic              m0_wr_en;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic [63:0]       m0_rdata;
  logic              m0_ready;

  logic              m1_rd_en;
  logic              m1_wr_en;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic [63:0]       m1_rdata;
  logic              m1_ready;

  logic              s_rd_en;
  logic              s_wr_en;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic [63:0]       s_rdata;
  logic              s_ready;

  logic [1:0]        grant;

  modport master (
    output m0_rd_en, m0_wr_en, m0_addr, m0_wdata,
    input  m0_rdata, m0_ready,
    output m1_rd_en, m1_wr_en, m1_addr, m1_wdata,
    input  m1_rdata, m1_ready,
    input  s_rd_en, s_wr_en, s_addr, s_wdata,
    output s_rdata, s_ready,
    input  grant
  );

  modport slave (
    input  m0_rd_en, m0_wr_en, m0_addr, m0_wdata,
    output m0_rdata, m0_ready,
    input  m1_rd_en, m1_wr_en, m1_addr, m1_wdata,
    output m1_rdata, m1_ready,
    output s_rd_en, s_wr_en, s_addr, s_wdata,
    input  s_rdata, s_ready,
    output grant
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
// Shares one SRAM_Controller port between instruction fetch (master 0) and
// the MEM-stage cache controller (master 1). A winning request is latched,
// driven to the controller until its ready pulse, and then completed toward
// the winner only with a one-cycle ready (and read data for reads).
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : sram_port_arbiter_if.slave (requesters, controller, grant)
// Parameters:
//   RR_MODE : 0 = master 1 wins ties, 1 = round-robin on ties
//   ADDR_W  : request address width
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int RR_MODE = 0,
  parameter int ADDR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_port_arbiter_if.slave    bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] BUSY0 = 3'd1;
  localparam logic [2:0] BUSY1 = 3'd2;
  localparam logic [2:0] DONE0 = 3'd3;
  localparam logic [2:0] DONE1 = 3'd4;

  localparam logic LP_RR = (RR_MODE != 0);

  logic [2:0]        r_state;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_last_grant;   // 1 = master 1 was granted last
  logic [63:0]       r_m0_rdata;
  logic [63:0]       r_m1_rdata;

  logic w_req0;
  logic w_req1;
  logic w_pick1;
  logic w_busy;

  assign w_req0 = bus.m0_rd_en | bus.m0_wr_en;
  assign w_req1 = bus.m1_rd_en | bus.m1_wr_en;
  // Master 1 wins when it is the only requester, or on a tie when fixed
  // priority is selected or master 0 already had the last turn.
  assign w_pick1 = w_req1 & (~w_req0 | ~LP_RR | ~r_last_grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_op_wr      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_last_grant <= 1'b1;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0 | w_req1) begin
            r_last_grant <= w_pick1;
            // A write enable overrides a simultaneous read enable.
            if (w_pick1) begin
              r_op_wr <= bus.m1_wr_en;
              r_addr  <= bus.m1_addr;
              r_wdata <= bus.m1_wdata;
              r_state <= BUSY1;
            end else begin
              r_op_wr <= bus.m0_wr_en;
              r_addr  <= bus.m0_addr;
              r_wdata <= bus.m0_wdata;
              r_state <= BUSY0;
            end
          end
        end
        BUSY0: begin
          if (bus.s_ready) begin
            if (!r_op_wr) r_m0_rdata <= bus.s_rdata;
            r_state <= DONE0;
          end
        end
        BUSY1: begin
          if (bus.s_ready) begin
            if (!r_op_wr) r_m1_rdata <= bus.s_rdata;
            r_state <= DONE1;
          end
        end
        // DONE always passes through IDLE, guaranteeing a gap between
        // consecutive controller operations.
        DONE0, DONE1: r_state <= IDLE;
        default:      r_state <= IDLE;
      endcase
    end
  end

  // All outputs come from registers or state decode only.
  assign w_busy      = (r_state == BUSY0) | (r_state == BUSY1);
  assign bus.s_rd_en = w_busy & ~r_op_wr;
  assign bus.s_wr_en = w_busy &  r_op_wr;
  assign bus.s_addr  = r_addr;
  assign bus.s_wdata = r_wdata;
  assign bus.grant   = {(r_state == BUSY1) | (r_state == DONE1),
                        (r_state == BUSY0) | (r_state == DONE0)};
  assign bus.m0_ready = (r_state == DONE0);
  assign bus.m1_ready = (r_state == DONE1);
  assign bus.m0_rdata = r_m0_rdata;
  assign bus.m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
// Two arbiter instances: g_dut[0] with RR_MODE=0, g_dut[1] with RR_MODE=1.
// A transaction-level model predicts every output each cycle; directed
// sequences add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Requester side, indexed [instance][master]
  logic        rd_en [2][2];
  logic        wr_en [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [63:0] rdata [2][2];
  logic        ready [2][2];
  // Controller side, indexed [instance]
  logic        s_rd  [2];
  logic        s_wr  [2];
  logic [31:0] s_addr[2];
  logic [31:0] s_wd  [2];
  logic [1:0]  grant [2];
  logic        s_ready[2] = '{1'b0, 1'b0};
  logic [63:0] rsp_data[2];
  int          rsp_lat [2];
  int          rsp_cnt [2] = '{0, 0};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_port_arbiter_if #(.ADDR_W(32)) bus ();
    sram_port_arbiter #(.RR_MODE(g), .ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.m0_rd_en = rd_en[g][0];
    assign bus.m0_wr_en = wr_en[g][0];
    assign bus.m0_addr  = addr[g][0];
    assign bus.m0_wdata = wdata[g][0];
    assign bus.m1_rd_en = rd_en[g][1];
    assign bus.m1_wr_en = wr_en[g][1];
    assign bus.m1_addr  = addr[g][1];
    assign bus.m1_wdata = wdata[g][1];
    assign bus.s_rdata  = rsp_data[g];
    assign bus.s_ready  = s_ready[g];
    assign rdata[g][0]  = bus.m0_rdata;
    assign ready[g][0]  = bus.m0_ready;
    assign rdata[g][1]  = bus.m1_rdata;
    assign ready[g][1]  = bus.m1_ready;
    assign s_rd[g]      = bus.s_rd_en;
    assign s_wr[g]      = bus.s_wr_en;
    assign s_addr[g]    = bus.s_addr;
    assign s_wd[g]      = bus.s_wdata;
    assign grant[g]     = bus.grant;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // SRAM_Controller stand-in: pulses s_ready once the request has been seen
  // for rsp_lat cycles (s_ready then sampled rsp_lat edges after the grant).
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (s_rd[d] | s_wr[d]) begin
        if (rsp_cnt[d] == rsp_lat[d] - 1) begin
          s_ready[d] <= 1'b1;
          rsp_cnt[d] <= 0;
        end else begin
          s_ready[d] <= 1'b0;
          rsp_cnt[d] <= rsp_cnt[d] + 1;
        end
      end else begin
        s_ready[d] <= 1'b0;
        rsp_cnt[d] <= 0;
      end
    end
  end

  // Transaction model: one in-flight transfer per instance (owner, op,
  // address, data) plus a "finished" flag for the completion cycle.
  logic        mv_act [2];
  logic        mv_fin [2];
  logic        mv_wr  [2];
  logic        mv_who [2];
  logic        mv_last[2];
  logic [31:0] mv_addr[2];
  logic [31:0] mv_wd  [2];
  logic [63:0] mv_rdata[2][2];

  function automatic logic wants(input int d, input int m);
    return rd_en[d][m] | wr_en[d][m];
  endfunction

  // Winner of an arbitration round: 1 means master 1.
  function automatic logic winner(input int d);
    if (!wants(d, 1)) return 1'b0;
    if (!wants(d, 0)) return 1'b1;
    if (d == 0) return 1'b1;          // instance 0: fixed priority to master 1
    return ~mv_last[d];               // instance 1: the other master's turn
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        mv_act[d]      <= 1'b0;
        mv_fin[d]      <= 1'b0;
        mv_wr[d]       <= 1'b0;
        mv_who[d]      <= 1'b0;
        mv_last[d]     <= 1'b1;
        mv_addr[d]     <= '0;
        mv_wd[d]       <= '0;
        mv_rdata[d][0] <= '0;
        mv_rdata[d][1] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mv_act[d] && mv_fin[d]) begin
          mv_act[d] <= 1'b0;
          mv_fin[d] <= 1'b0;
        end else if (mv_act[d]) begin
          if (s_ready[d]) begin
            mv_fin[d] <= 1'b1;
            if (!mv_wr[d]) mv_rdata[d][mv_who[d]] <= rsp_data[d];
          end
        end else if (wants(d, 0) || wants(d, 1)) begin
          mv_act[d]  <= 1'b1;
          mv_fin[d]  <= 1'b0;
          mv_who[d]  <= winner(d);
          mv_last[d] <= winner(d);
          mv_wr[d]   <= wr_en[d][winner(d)];
          mv_addr[d] <= addr[d][winner(d)];
          mv_wd[d]   <= wdata[d][winner(d)];
        end
      end
    end
  end

  // Cycle compare against the model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("i%0d_m%0d_rdata", d, m), rdata[d][m], mv_rdata[d][m]);
        check($sformatf("i%0d_m%0d_ready", d, m), 64'(ready[d][m]),
              64'(mv_act[d] && mv_fin[d] && (mv_who[d] == (m == 1))));
      end
      check($sformatf("i%0d_s_rd_en", d), 64'(s_rd[d]), 64'(mv_act[d] && !mv_fin[d] && !mv_wr[d]));
      check($sformatf("i%0d_s_wr_en", d), 64'(s_wr[d]), 64'(mv_act[d] && !mv_fin[d] && mv_wr[d]));
      check($sformatf("i%0d_s_addr", d), 64'(s_addr[d]), 64'(mv_addr[d]));
      check($sformatf("i%0d_s_wdata", d), 64'(s_wd[d]), 64'(mv_wd[d]));
      check($sformatf("i%0d_grant", d), 64'(grant[d]),
            mv_act[d] ? (mv_who[d] ? 64'd2 : 64'd1) : 64'd0);
    end
  end

  // Record grant order of each instance (a new grant follows an idle cycle)
  logic [1:0] prev_g[2] = '{2'b00, 2'b00};
  int gq0[$];
  int gq1[$];
  always @(negedge clk) begin
    if (grant[0] != 2'b00 && prev_g[0] == 2'b00) gq0.push_back(int'(grant[0]));
    if (grant[1] != 2'b00 && prev_g[1] == 2'b00) gq1.push_back(int'(grant[1]));
    prev_g[0] <= grant[0];
    prev_g[1] <= grant[1];
  end

  task automatic set_req(input int d, input int m, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] w);
    rd_en[d][m] = rd;
    wr_en[d][m] = wr;
    addr[d][m]  = a;
    wdata[d][m] = w;
  endtask

  // Returns the number of rising edges until ready is visible, or -1.
  task automatic wait_ready(input int d, input int m, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (ready[d][m] === 1'b1) begin
        n = i;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_ready_i%0d_m%0d: got no ready, expected one within %0d cycles", d, m, budget);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1);
  end

  int n;
  int exp_rr[4] = '{1, 2, 1, 2};

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) set_req(d, m, 1'b0, 1'b0, 32'h0, 32'h0);
      rsp_data[d] = 64'h0;
      rsp_lat[d]  = 6;
    end
    rsp_lat[1] = 3;
    #1 rst = 1'b0;
    #1;
    check("rst_grant", 64'(grant[0]), 64'd0);
    check("rst_s_addr", 64'(s_addr[0]), 64'd0);
    check("rst_m0_rdata", rdata[0][0], 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Single read from master 0; ready lands in the 8th cycle counting the
    // request cycle: grant edge + 6 BUSY edges = 7 edges after raising it.
    @(posedge clk); #3;
    rsp_data[0] = 64'h1122334455667788;
    set_req(0, 0, 1'b1, 1'b0, 32'h100, 32'h0);
    wait_ready(0, 0, 30, n);
    check("t1_latency", 64'(n), 64'd7);
    check("t1_m0_rdata", rdata[0][0], 64'h1122334455667788);
    check("t1_m1_ready", 64'(ready[0][1]), 64'd0);
    @(posedge clk); #3;
    set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Fixed priority: simultaneous m0 read and m1 write, m1 first
    @(posedge clk); #3;
    rsp_data[0] = 64'hA5A5A5A5_5A5A5A5A;
    set_req(0, 0, 1'b1, 1'b0, 32'h300, 32'h0);
    set_req(0, 1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("t2_grant_m1", 64'(grant[0]), 64'd2);
    check("t2_s_wr_en", 64'(s_wr[0]), 64'd1);
    check("t2_s_addr", 64'(s_addr[0]), 64'h40);
    check("t2_s_wdata", 64'(s_wd[0]), 64'hDEADBEEF);
    wait_ready(0, 1, 30, n);
    @(posedge clk); #1;
    check("t2_idle_gap", 64'(grant[0]), 64'd0);
    #2 set_req(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("t2_grant_m0", 64'(grant[0]), 64'd1);
    check("t2_m0_addr", 64'(s_addr[0]), 64'h300);
    wait_ready(0, 0, 30, n);
    check("t2_m0_rdata", rdata[0][0], 64'hA5A5A5A5_5A5A5A5A);
    check("t2_m1_rdata", rdata[0][1], 64'd0);
    @(posedge clk); #3;
    set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Both enables high: issued as a write, read data left alone
    @(posedge clk); #3;
    set_req(0, 0, 1'b1, 1'b1, 32'h500, 32'h12345678);
    @(posedge clk); #1;
    check("t5_s_wr_en", 64'(s_wr[0]), 64'd1);
    check("t5_s_rd_en", 64'(s_rd[0]), 64'd0);
    check("t5_s_wdata", 64'(s_wd[0]), 64'h12345678);
    wait_ready(0, 0, 30, n);
    check("t5_m0_rdata", rdata[0][0], 64'hA5A5A5A5_5A5A5A5A);
    @(posedge clk); #3;
    set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);

    // m1 drops its read and changes address two cycles into BUSY1
    @(posedge clk); #3;
    rsp_data[0] = 64'hCAFEF00D_01234567;
    set_req(0, 1, 1'b1, 1'b0, 32'h200, 32'h0);
    @(posedge clk); #1;
    check("t4_grant_m1", 64'(grant[0]), 64'd2);
    repeat (2) @(posedge clk);
    #3 set_req(0, 1, 1'b0, 1'b0, 32'h999, 32'h0);
    @(posedge clk); #1;
    check("t4_s_addr_held", 64'(s_addr[0]), 64'h200);
    check("t4_s_rd_held", 64'(s_rd[0]), 64'd1);
    wait_ready(0, 1, 30, n);
    check("t4_m1_rdata", rdata[0][1], 64'hCAFEF00D_01234567);
    @(posedge clk); #1;
    check("t4_back_idle", 64'(grant[0]), 64'd0);

    // Round-robin instance, both masters requesting continuously
    @(posedge clk); #3;
    set_req(1, 0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1, 1, 1'b1, 1'b0, 32'h20, 32'h0);
    begin
      int k;
      k = 0;
      for (int i = 0; i < 100 && k < 4; i++) begin
        @(posedge clk); #1;
        if (ready[1][0] === 1'b1 || ready[1][1] === 1'b1) k++;
      end
      check("t3_ready_count", 64'(k), 64'd4);
    end
    @(posedge clk); #3;
    set_req(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    check("t3_grant_count", 64'(gq1.size()), 64'd4);
    for (int i = 0; i < 4 && i < gq1.size(); i++)
      check($sformatf("t3_grant_order_%0d", i), 64'(gq1[i]), 64'(exp_rr[i]));

    // Asynchronous reset in the middle of BUSY0
    #3;
    set_req(0, 0, 1'b1, 1'b0, 32'h700, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_grant", 64'(grant[0]), 64'd0);
    check("t6_s_rd_en", 64'(s_rd[0]), 64'd0);
    check("t6_s_addr", 64'(s_addr[0]), 64'd0);
    check("t6_m0_rdata", rdata[0][0], 64'd0);
    check("t6_m1_rdata", rdata[0][1], 64'd0);
    set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #3;
    rsp_data[0] = 64'h0BADF00D_DEADC0DE;
    set_req(0, 1, 1'b1, 1'b0, 32'h800, 32'h0);
    wait_ready(0, 1, 30, n);
    check("t6_after_latency", 64'(n), 64'd7);
    check("t6_after_rdata", rdata[0][1], 64'h0BADF00D_DEADC0DE);
    @(posedge clk); #3;
    set_req(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
